// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multi-cycle sequencer with memory handshake, stall, trap and retire counter.
package rv32i_pkg;
    typedef enum logic [6:0] {
        R_TYPE      = 7'b0110011,
        I_TYPE      = 7'b0010011,
        I_LOAD_TYPE = 7'b0000011,
        S_TYPE      = 7'b0100011,
        B_TYPE      = 7'b1100011,
        J_TYPE      = 7'b1101111,
        I_JALR_TYPE = 7'b1100111,
        U_AUI_TYPE  = 7'b0010111,
        U_LUI_TYPE  = 7'b0110111
    } RV32I_OPCODE_t;
endpackage

module multicycle_control_unit
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT  = 15,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  RV32I_OPCODE_t       opcode,
    input  logic                stall,
    input  logic                mem_ready,
    input  logic                trap_clear,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                ir_wren,
    output logic                pc_wren,
    output logic                rf_wren,
    output logic [2:0]          state,
    output logic [RETIRE_W-1:0] retire_count,
    output logic                trap,
    output logic                timeout_err
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       wait_q, wait_d;
    logic [RETIRE_W-1:0] retire_q;
    logic                terr_q, terr_d;
    logic                legal, waiting, expired, retire;

    assign legal = opcode inside {R_TYPE, I_TYPE, I_LOAD_TYPE, S_TYPE, B_TYPE,
                                  J_TYPE, I_JALR_TYPE, U_AUI_TYPE, U_LUI_TYPE};

    // wait counter only runs while a request is outstanding; any other cycle zeroes it
    assign waiting = ((state_q == FETCH && !stall) || state_q == MEMORY) && !mem_ready;
    assign expired = (TIMEOUT > 0) && waiting && wait_q == CW'(TIMEOUT - 1);
    assign wait_d  = (waiting && !expired) ? wait_q + 1'b1 : '0;

    assign retire = (state_q == EXECUTE && opcode == B_TYPE)
                 || (state_q == MEMORY && mem_ready && opcode == S_TYPE)
                 || state_q == WRITEBACK;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:     state_d = stall ? FETCH : mem_ready ? DECODE : expired ? TRAP : FETCH;
            DECODE:    state_d = legal ? EXECUTE : TRAP;
            EXECUTE:   state_d = (opcode == I_LOAD_TYPE || opcode == S_TYPE) ? MEMORY
                               : opcode == B_TYPE ? FETCH : WRITEBACK;
            MEMORY:    state_d = mem_ready ? (opcode == S_TYPE ? FETCH : WRITEBACK)
                               : expired ? TRAP : MEMORY;
            WRITEBACK: state_d = FETCH;
            TRAP:      state_d = trap_clear ? FETCH : TRAP;
            default:   state_d = FETCH;
        endcase
    end

    assign terr_d = expired ? 1'b1 : (state_q == TRAP && trap_clear) ? 1'b0 : terr_q;

    // strobes are masked while reset is asserted so an aborted instruction has no side effects
    assign imem_req = rst && state_q == FETCH && !stall;
    assign ir_wren  = imem_req && mem_ready;
    assign dmem_req = rst && state_q == MEMORY;
    assign dmem_we  = dmem_req && opcode == S_TYPE;
    assign pc_wren  = rst && retire;
    assign rf_wren  = rst && state_q == WRITEBACK;

    assign state        = state_q;
    assign trap         = state_q == TRAP;
    assign timeout_err  = terr_q;
    assign retire_count = retire_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= FETCH;
            wait_q   <= '0;
            retire_q <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            retire_q <= retire ? retire_q + 1'b1 : retire_q;
            terr_q   <= terr_d;
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboarded per-cycle check of state, strobes and retire counter.
module tb_multicycle_control_unit;
    import rv32i_pkg::*;

    localparam logic [6:0] OP_ADD = 7'h33;
    localparam logic [6:0] OP_LW  = 7'h03;
    localparam logic [6:0] OP_SW  = 7'h23;
    localparam logic [6:0] OP_BEQ = 7'h63;
    localparam logic [6:0] OP_ILL = 7'h7F;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    RV32I_OPCODE_t opcode;
    logic          stall = 1'b0, mem_ready = 1'b1, trap_clear = 1'b0;
    logic          imem_req, dmem_req, dmem_we, ir_wren, pc_wren, rf_wren, trap, timeout_err;
    logic [2:0]    state;
    logic [31:0]   retire_count;
    logic          n_imem, n_dmem, n_we, n_ir, n_pc, n_rf, n_trap, n_terr;
    logic [2:0]    n_state;
    logic [3:0]    n_retire;
    logic [31:0]   obs;
    logic [31:0]   exp_q[$];
    int            n_chk = 0, n_pass = 0;

    multicycle_control_unit #(.TIMEOUT(15), .RETIRE_W(32)) u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .stall(stall), .mem_ready(mem_ready),
        .trap_clear(trap_clear), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_wren(ir_wren), .pc_wren(pc_wren), .rf_wren(rf_wren), .state(state),
        .retire_count(retire_count), .trap(trap), .timeout_err(timeout_err)
    );

    multicycle_control_unit #(.TIMEOUT(15), .RETIRE_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .stall(stall), .mem_ready(mem_ready),
        .trap_clear(trap_clear), .imem_req(n_imem), .dmem_req(n_dmem), .dmem_we(n_we),
        .ir_wren(n_ir), .pc_wren(n_pc), .rf_wren(n_rf), .state(n_state),
        .retire_count(n_retire), .trap(n_trap), .timeout_err(n_terr)
    );

    always #5 clk = ~clk;

    assign obs = {21'b0, state, imem_req, dmem_req, dmem_we, ir_wren, pc_wren, rf_wren, trap, timeout_err};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    // f = {imem_req, dmem_req, dmem_we, ir_wren, pc_wren, rf_wren, trap, timeout_err}
    function automatic logic [31:0] ev(input logic [2:0] st, input logic [7:0] f);
        return {21'b0, st, f};
    endfunction

    task automatic cyc(input string tag, input logic [6:0] op, input bit s, input bit m,
                       input bit tc, input bit r, input logic [31:0] e);
        @(negedge clk);
        opcode = RV32I_OPCODE_t'(op);
        stall = s;
        mem_ready = m;
        trap_clear = tc;
        rst = r;
        exp_q.push_back(e);
        #1 check(tag, obs, exp_q.pop_front());
    endtask

    task automatic ret(input int w);
        @(posedge clk);
        #1;
        check("retire", retire_count, w);
        check("retire4", {28'b0, n_retire}, w % 16);
    endtask

    initial begin
        opcode = RV32I_OPCODE_t'(OP_ADD);
        cyc("reset", OP_ADD, 0, 1, 0, 0, ev(0, 8'b0000_0000));
        ret(0);
        // ADD
        cyc("add_f", OP_ADD, 0, 1, 0, 1, ev(0, 8'b1001_0000));
        cyc("add_d", OP_ADD, 0, 1, 0, 1, ev(1, 8'b0000_0000));
        cyc("add_e", OP_ADD, 0, 1, 0, 1, ev(2, 8'b0000_0000));
        cyc("add_wb", OP_ADD, 0, 1, 0, 1, ev(4, 8'b0000_1100));
        ret(1);
        // LW with three memory wait cycles
        cyc("lw_f", OP_LW, 0, 1, 0, 1, ev(0, 8'b1001_0000));
        cyc("lw_d", OP_LW, 0, 1, 0, 1, ev(1, 8'b0000_0000));
        cyc("lw_e", OP_LW, 0, 1, 0, 1, ev(2, 8'b0000_0000));
        for (int i = 0; i < 3; i++) cyc("lw_mwait", OP_LW, 0, 0, 0, 1, ev(3, 8'b0100_0000));
        cyc("lw_m", OP_LW, 0, 1, 0, 1, ev(3, 8'b0100_0000));
        cyc("lw_wb", OP_LW, 0, 1, 0, 1, ev(4, 8'b0000_1100));
        ret(2);
        // SW then BEQ
        cyc("sw_f", OP_SW, 0, 1, 0, 1, ev(0, 8'b1001_0000));
        cyc("sw_d", OP_SW, 0, 1, 0, 1, ev(1, 8'b0000_0000));
        cyc("sw_e", OP_SW, 0, 1, 0, 1, ev(2, 8'b0000_0000));
        cyc("sw_m", OP_SW, 0, 1, 0, 1, ev(3, 8'b0110_1000));
        cyc("beq_f", OP_BEQ, 0, 1, 0, 1, ev(0, 8'b1001_0000));
        cyc("beq_d", OP_BEQ, 0, 1, 0, 1, ev(1, 8'b0000_0000));
        cyc("beq_e", OP_BEQ, 0, 1, 0, 1, ev(2, 8'b0000_1000));
        ret(4);
        // fetch timeout
        for (int i = 0; i < 15; i++) cyc("to_fwait", OP_ADD, 0, 0, 0, 1, ev(0, 8'b1000_0000));
        cyc("to_trap", OP_ADD, 0, 0, 0, 1, ev(5, 8'b0000_0011));
        cyc("to_clr", OP_ADD, 0, 0, 1, 1, ev(5, 8'b0000_0011));
        cyc("to_after", OP_ADD, 1, 0, 0, 1, ev(0, 8'b0000_0000));
        // ready arrives in the limit cycle
        for (int i = 0; i < 14; i++) cyc("lim_fwait", OP_ADD, 0, 0, 0, 1, ev(0, 8'b1000_0000));
        cyc("lim_f", OP_ADD, 0, 1, 0, 1, ev(0, 8'b1001_0000));
        cyc("lim_d", OP_ADD, 0, 1, 0, 1, ev(1, 8'b0000_0000));
        cyc("lim_e", OP_ADD, 0, 1, 0, 1, ev(2, 8'b0000_0000));
        cyc("lim_wb", OP_ADD, 0, 1, 0, 1, ev(4, 8'b0000_1100));
        ret(5);
        // illegal opcode
        cyc("ill_f", OP_ILL, 0, 1, 0, 1, ev(0, 8'b1001_0000));
        cyc("ill_d", OP_ILL, 0, 1, 0, 1, ev(1, 8'b0000_0000));
        cyc("ill_trap", OP_ILL, 0, 1, 0, 1, ev(5, 8'b0000_0010));
        cyc("ill_clr", OP_ILL, 0, 1, 1, 1, ev(5, 8'b0000_0010));
        ret(5);
        // stall, then reset while in MEMORY
        for (int i = 0; i < 5; i++) cyc("stall", OP_LW, 1, 1, 0, 1, ev(0, 8'b0000_0000));
        cyc("rs_f", OP_LW, 0, 1, 0, 1, ev(0, 8'b1001_0000));
        cyc("rs_d", OP_LW, 0, 1, 0, 1, ev(1, 8'b0000_0000));
        cyc("rs_e", OP_LW, 0, 1, 0, 1, ev(2, 8'b0000_0000));
        cyc("rs_mwait", OP_LW, 0, 0, 0, 1, ev(3, 8'b0100_0000));
        cyc("rs_assert", OP_LW, 0, 0, 0, 0, ev(3, 8'b0000_0000));
        ret(0);
        cyc("rs_after", OP_LW, 1, 1, 0, 1, ev(0, 8'b0000_0000));
        // 16 branches wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            cyc("wrap_f", OP_BEQ, 0, 1, 0, 1, ev(0, 8'b1001_0000));
            cyc("wrap_d", OP_BEQ, 0, 1, 0, 1, ev(1, 8'b0000_0000));
            cyc("wrap_e", OP_BEQ, 0, 1, 0, 1, ev(2, 8'b0000_1000));
            if (i == 14) ret(15);
        end
        ret(16);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multi-cycle control FSM for the RV32I core front-end. Sequences each instruction through FETCH, DECODE, EXECUTE, an optional MEMORY phase and WRITEBACK, and drives the register-file, PC, IR and memory-request strobes. Unlike the fixed four-state sequencer, it handshakes with instruction and data memory through `mem_ready`, supports external stall, and traps on illegal opcodes or memory timeout. It also counts retired instructions. It sits between the decoder (`opcode`) and the datapath/memory ports.

## Interface
- `TIMEOUT`, 15: max consecutive cycles waiting for `mem_ready` in FETCH/MEMORY before trapping; 0 disables the timeout.
- `RETIRE_W`, 32: width of the retired-instruction counter.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `opcode`  in  RV32I_OPCODE_t  opcode of the instruction held in the IR.
- `stall`  in  1  holds the FSM in FETCH before a request is issued.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `trap_clear`  in  1  leaves TRAP and clears `timeout_err`.
- `imem_req`  out  1  instruction-fetch request.
- `dmem_req`  out  1  data-memory request.
- `dmem_we`  out  1  data-memory write (store).
- `ir_wren`  out  1  IR load strobe.
- `pc_wren`  out  1  PC update strobe.
- `rf_wren`  out  1  register-file write enable.
- `state`  out  3  current state: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5.
- `retire_count`  out  RETIRE_W  retired instructions, wraps modulo 2^RETIRE_W.
- `trap`  out  1  high while in TRAP.
- `timeout_err`  out  1  sticky: set when the last trap was caused by a timeout.

## Operation
- Reset (`rst`=0 at an edge) forces state=FETCH, wait counter=0, `retire_count`=0, `timeout_err`=0. It aborts any instruction in flight; no strobe fires in that cycle.
- All strobes are combinational from state, `opcode`, `mem_ready` and `stall`. All strobes are 0 in any state not listed below.
- Legal opcodes: R_TYPE, I_TYPE, I_LOAD_TYPE, S_TYPE, B_TYPE, J_TYPE, I_JALR_TYPE, U_AUI_TYPE, U_LUI_TYPE.
- FETCH, when `stall`=1: no request, wait counter held at 0, stay in FETCH.
- FETCH, when `stall`=0: `imem_req`=1.
  - If `mem_ready`=1: `ir_wren`=1, next state DECODE.
- DECODE: illegal opcode -> TRAP with `timeout_err` unchanged (0). Otherwise -> EXECUTE.
- EXECUTE:
  - I_LOAD_TYPE or S_TYPE -> MEMORY.
  - B_TYPE: `pc_wren`=1, retire, -> FETCH.
  - All other legal opcodes -> WRITEBACK.
- MEMORY: `dmem_req`=1; `dmem_we`=1 iff S_TYPE.
  - `mem_ready`=1 and load -> WRITEBACK.
  - `mem_ready`=1 and store: `pc_wren`=1, retire, -> FETCH.
- WRITEBACK: `rf_wren`=1 (every opcode reaching here writes), `pc_wren`=1, retire, -> FETCH.
- TRAP: `trap`=1, all strobes 0.
  - `trap_clear`=1 -> FETCH and `timeout_err`<=0.
  - `rst` takes priority over `trap_clear`.
- Retire: `retire_count` increments by 1 on the edge that leaves the retiring state. It wraps from all-ones to 0.
- Timeout (TIMEOUT>0):
  - Wait counter is zeroed on entry to FETCH/MEMORY.
  - It increments each non-stalled cycle with `mem_ready`=0.
  - If the counter equals TIMEOUT-1 and `mem_ready`=0 -> TRAP with `timeout_err`<=1.
  - `mem_ready`=1 in the limit cycle completes normally.
  - Counter width is $clog2(TIMEOUT+1).

## Timing
- Cycles per instruction with zero-wait memory:
  - ALU/U/J/JALR: 4 (F,D,E,WB).
  - Branch: 3 (F,D,E).
  - Store: 4 (F,D,E,M).
  - Load: 5 (F,D,E,M,WB).
- Each memory wait cycle adds 1 cycle. Each stall cycle adds 1 cycle in FETCH.
- `ir_wren`, `pc_wren` and `rf_wren` are single-cycle pulses per instruction. `rf_wren` and `pc_wren` coincide in WRITEBACK.
- After reset release, `imem_req`=1 in the first cycle unless `stall`=1.
- A timeout trap is entered exactly TIMEOUT cycles after the request began, counting only non-stalled cycles.

## Test plan
- ADD (R_TYPE), `mem_ready`=1 always:
  - states 0,1,2,4,0.
  - `ir_wren` in cycle 1, `rf_wren`=`pc_wren`=1 in cycle 4.
  - `retire_count` 0->1.
- LW with `mem_ready` low 3 cycles in MEMORY:
  - MEMORY lasts 4 cycles with `dmem_req`=1, `dmem_we`=0.
  - Then WRITEBACK; total 8 cycles; `retire_count` +1.
- SW then BEQ back-to-back:
  - store: `dmem_we`=1 in MEMORY, no `rf_wren`, 4 cycles.
  - branch: 3 cycles, `pc_wren` in EXECUTE.
  - `retire_count`=2.
- Timeout, TIMEOUT=15, `mem_ready`=0 in FETCH:
  - TRAP entered after 15 request cycles; `trap`=1, `timeout_err`=1.
  - `trap_clear` pulse -> FETCH, `timeout_err`=0.
  - Repeat with `mem_ready`=1 on the 15th cycle -> no trap.
- Illegal opcode 7'h7F:
  - F, D, then TRAP with `timeout_err`=0; no `rf_wren`/`pc_wren`; `retire_count` unchanged.
- `stall` held 5 cycles, then reset mid-instruction:
  - during stall, `imem_req`=0 and `state`=0 throughout.
  - asserting `rst`=0 in MEMORY -> next cycle state=0, `retire_count`=0, no `rf_wren`.
  - with RETIRE_W=4, 16 retirements wrap `retire_count` to 0.
